// File: rtl/qdr_usr_pkg.sv
// qdr_usr_pkg
//   Shared definitions for the QDR user-port initiator:
//   - default user-port widths (address 22, data 36, byte enables 4)
//   - request record type {rnw, addr, wdata, be} at the default widths
//   - FSM state encoding for the request gate
//   - credit_w(): width of a counter that must hold 0..max_out inclusive
package qdr_usr_pkg;

    localparam int QDR_ADDR_W = 22;
    localparam int QDR_DATA_W = 36;
    localparam int QDR_BE_W   = 4;

    typedef struct packed {
        logic                  rnw;
        logic [QDR_ADDR_W-1:0] addr;
        logic [QDR_DATA_W-1:0] wdata;
        logic [QDR_BE_W-1:0]   be;
    } qdr_req_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } qdr_state_t;

    // A count of 0..max_out needs one bit more than log2(max_out) when
    // max_out is a power of two.
    function automatic int credit_w(input int max_out);
        return $clog2(max_out) + 1;
    endfunction

endpackage

// File: rtl/qdr_rsp_fifo.sv
// qdr_rsp_fifo
//   Synchronous first-word-fall-through FIFO holding returned read data.
//   The head entry is presented on dout whenever the FIFO is not empty;
//   a push into an empty FIFO is visible on the following cycle.
//   Push and pop in the same cycle are legal on a full FIFO.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write side
//   pop             consume head (ignored when empty)
//   dout            head entry, forced to 0 while empty
//   full, empty     status
//   count           number of entries held (0..DEPTH)
module qdr_rsp_fifo
    import qdr_usr_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [credit_w(DEPTH)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = credit_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);

    // Storage is data only; it needs no reset because dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr];

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop))
        else $error("qdr_rsp_fifo: push into full FIFO without pop");

endmodule

// File: rtl/qdr_usr_master.sv
// qdr_usr_master
//   Initiator for the QDR controller user port. Takes single-beat read/write
//   requests on a valid/ready channel, issues one-cycle registered strobes to
//   the controller, limits outstanding reads with credits, and returns read
//   data in order through an FWFT response FIFO.
// Ports:
//   clk0, reset_n                  user clock, asynchronous active-low reset
//   phy_rdy, cal_fail              controller calibration status
//   req_valid/req_ready/req_rnw/req_addr/req_wdata/req_be
//                                  request channel
//   rsp_valid/rsp_ready/rsp_data   in-order read response channel
//   usr_addr/usr_wr_strb/usr_wr_data/usr_wr_be/usr_rd_strb
//                                  registered controller commands
//   usr_rd_data/usr_rd_dvld        controller read return
//   err_clr                        clears the sticky error flags
//   rd_timeout, rd_spurious        sticky error flags
//   inflight                       reads issued and not yet returned
module qdr_usr_master
    import qdr_usr_pkg::*;
#(
    parameter int ADDR_WIDTH      = QDR_ADDR_W,
    parameter int DATA_WIDTH      = QDR_DATA_W,
    parameter int BE_WIDTH        = QDR_BE_W,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT         = 1024
) (
    input  logic                                   clk0,
    input  logic                                   reset_n,
    input  logic                                   phy_rdy,
    input  logic                                   cal_fail,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_rnw,
    input  logic [ADDR_WIDTH-1:0]                  req_addr,
    input  logic [DATA_WIDTH-1:0]                  req_wdata,
    input  logic [BE_WIDTH-1:0]                    req_be,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [DATA_WIDTH-1:0]                  rsp_data,
    output logic [ADDR_WIDTH-1:0]                  usr_addr,
    output logic                                   usr_wr_strb,
    output logic [DATA_WIDTH-1:0]                  usr_wr_data,
    output logic [BE_WIDTH-1:0]                    usr_wr_be,
    output logic                                   usr_rd_strb,
    input  logic [DATA_WIDTH-1:0]                  usr_rd_data,
    input  logic                                   usr_rd_dvld,
    input  logic                                   err_clr,
    output logic                                   rd_timeout,
    output logic                                   rd_spurious,
    output logic [credit_w(MAX_OUTSTANDING)-1:0]   inflight
);

    localparam int CW = credit_w(MAX_OUTSTANDING);
    localparam int TW = $clog2(TIMEOUT);

    qdr_state_t    state;
    logic          ready_base;
    logic [CW:0]   credits;
    logic          rd_credit_ok;
    logic          wr_accept;
    logic          rd_accept;
    logic          rd_return;
    logic          spurious_set;
    logic          timeout_hit;
    logic [TW-1:0] to_cnt;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    assign ready_base = phy_rdy & ~cal_fail;

    // The read being strobed this cycle is not yet in inflight, so it is
    // counted separately to keep the credit total exact.
    assign credits = {1'b0, inflight} + {1'b0, fifo_count}
                   + {{CW{1'b0}}, usr_rd_strb};
    assign rd_credit_ok = (credits < (CW+1)'(MAX_OUTSTANDING));

    // ready_base is used directly so loss of calibration drops ready at once.
    assign req_ready = (state == ST_ACTIVE) & ready_base
                     & (~req_rnw | rd_credit_ok);
    assign wr_accept = req_valid & req_ready & ~req_rnw;
    assign rd_accept = req_valid & req_ready &  req_rnw;

    assign rd_return    = usr_rd_dvld & (inflight != '0);
    assign spurious_set = usr_rd_dvld & (inflight == '0);
    assign timeout_hit  = (inflight != '0) & ~usr_rd_dvld
                        & (to_cnt == TW'(TIMEOUT - 1));

    assign fifo_pop  = rsp_valid & rsp_ready;
    assign rsp_valid = ~fifo_empty;

    // Request gate FSM
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (ready_base)  state <= ST_ACTIVE;
                ST_ACTIVE: if (!ready_base) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Issue stage: accept in cycle N, strobe in cycle N+1. Address and write
    // payload keep their last values outside the strobe cycle.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            usr_wr_strb <= 1'b0;
            usr_rd_strb <= 1'b0;
            usr_addr    <= '0;
            usr_wr_data <= '0;
            usr_wr_be   <= '0;
        end else begin
            usr_wr_strb <= wr_accept;
            usr_rd_strb <= rd_accept;
            if (wr_accept || rd_accept) begin
                usr_addr <= req_addr;
            end
            if (wr_accept) begin
                usr_wr_data <= req_wdata;
                usr_wr_be   <= req_be;
            end
        end
    end

    // Read tracking: inflight and the no-return watchdog
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
            to_cnt   <= '0;
        end else begin
            if (timeout_hit) begin
                // Everything outstanding is abandoned; a read strobed this
                // very cycle is still live.
                inflight <= {{(CW-1){1'b0}}, usr_rd_strb};
            end else begin
                case ({usr_rd_strb, rd_return})
                    2'b10:   inflight <= inflight + CW'(1);
                    2'b01:   inflight <= inflight - CW'(1);
                    default: inflight <= inflight;
                endcase
            end

            if ((inflight == '0) || usr_rd_dvld || timeout_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // Sticky error flags; a new event wins over a clear in the same cycle.
    always_ff @(posedge clk0 or negedge reset_n) begin
        if (!reset_n) begin
            rd_timeout  <= 1'b0;
            rd_spurious <= 1'b0;
        end else begin
            if (timeout_hit) begin
                rd_timeout <= 1'b1;
            end else if (err_clr) begin
                rd_timeout <= 1'b0;
            end
            if (spurious_set) begin
                rd_spurious <= 1'b1;
            end else if (err_clr) begin
                rd_spurious <= 1'b0;
            end
        end
    end

    qdr_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk   (clk0),
        .rst_n (reset_n),
        .push  (rd_return),
        .din   (usr_rd_data),
        .pop   (fifo_pop),
        .dout  (rsp_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Credits bound the FIFO occupancy; a push into a full FIFO without a
    // simultaneous pop means the credit accounting is broken.
    credit_chk: assert property (@(posedge clk0) disable iff (!reset_n)
        !(rd_return && fifo_full && !fifo_pop))
        else $error("qdr_usr_master: response FIFO overflow");

endmodule

// File: tb/tb_qdr_usr_master.sv
// tb_qdr_usr_master
//   Directed bench for qdr_usr_master with a latency-based controller model,
//   plus a standalone response FIFO instance for the full push/pop case.
module tb_qdr_usr_master;
    import qdr_usr_pkg::*;

    localparam int AW     = 22;
    localparam int DW     = 36;
    localparam int BW     = 4;
    localparam int MAXO   = 8;
    localparam int TO     = 16;
    localparam int CWB    = 4;
    localparam int RD_LAT = 12;

    logic          clk0;
    logic          reset_n;
    logic          phy_rdy;
    logic          cal_fail;
    logic          req_valid;
    logic          req_ready;
    logic          req_rnw;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] usr_addr;
    logic          usr_wr_strb;
    logic [DW-1:0] usr_wr_data;
    logic [BW-1:0] usr_wr_be;
    logic          usr_rd_strb;
    logic [DW-1:0] usr_rd_data;
    logic          usr_rd_dvld;
    logic          err_clr;
    logic          rd_timeout;
    logic          rd_spurious;
    logic [CWB-1:0] inflight;

    // controller model and manual injection
    logic          mdl_dvld;
    logic [DW-1:0] mdl_data;
    logic          inj_dvld;
    logic [DW-1:0] inj_data;
    bit            mdl_mute;
    int unsigned   cyc;
    int unsigned   due_q[$];
    logic [DW-1:0] dat_q[$];

    assign usr_rd_dvld = mdl_dvld | inj_dvld;
    assign usr_rd_data = mdl_dvld ? mdl_data : inj_data;

    // standalone FIFO
    logic          f_push;
    logic          f_pop;
    logic [DW-1:0] f_din;
    logic [DW-1:0] f_dout;
    logic          f_full;
    logic          f_empty;
    logic [CWB-1:0] f_count;

    int n_chk;
    int n_bad;

    qdr_usr_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)
    ) dut (
        .clk0(clk0), .reset_n(reset_n), .phy_rdy(phy_rdy), .cal_fail(cal_fail),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .usr_addr(usr_addr), .usr_wr_strb(usr_wr_strb), .usr_wr_data(usr_wr_data),
        .usr_wr_be(usr_wr_be), .usr_rd_strb(usr_rd_strb), .usr_rd_data(usr_rd_data),
        .usr_rd_dvld(usr_rd_dvld), .err_clr(err_clr), .rd_timeout(rd_timeout),
        .rd_spurious(rd_spurious), .inflight(inflight)
    );

    qdr_rsp_fifo #(.DEPTH(MAXO), .WIDTH(DW)) u_fifo (
        .clk(clk0), .rst_n(reset_n), .push(f_push), .din(f_din), .pop(f_pop),
        .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Controller: a read strobed in cycle c returns in cycle c+RD_LAT with
    // data equal to its address. It is unaware of the initiator's reset.
    initial begin
        cyc = 0;
        mdl_dvld = 1'b0;
        mdl_data = '0;
        forever begin
            @(negedge clk0);
            if (reset_n && usr_rd_strb && !mdl_mute) begin
                due_q.push_back(cyc + RD_LAT);
                dat_q.push_back(DW'(usr_addr));
            end
            @(posedge clk0);
            #1;
            cyc++;
            mdl_dvld = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                mdl_dvld = 1'b1;
                mdl_data = dat_q.pop_front();
                void'(due_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Present a request, wait (bounded) for ready, let the edge accept it.
    task automatic issue(input logic rnw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be,
                         input string tag);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_rnw   = rnw;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        for (int i = 0; i < 50; i++) begin
            settle();
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 64'(ok), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    function automatic logic any_out();
        return |{req_ready, rsp_valid, rsp_data, usr_addr, usr_wr_strb,
                 usr_wr_data, usr_wr_be, usr_rd_strb, rd_timeout,
                 rd_spurious, inflight};
    endfunction

    initial begin
        qdr_req_t wv;
        int bad;
        int n;
        bit seen;

        n_chk = 0;
        n_bad = 0;
        reset_n = 1'b0;
        phy_rdy = 1'b0;
        cal_fail = 1'b0;
        req_valid = 1'b0;
        req_rnw = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_be = '0;
        rsp_ready = 1'b0;
        err_clr = 1'b0;
        inj_dvld = 1'b0;
        inj_data = '0;
        mdl_mute = 1'b0;
        f_push = 1'b0;
        f_pop = 1'b0;
        f_din = '0;

        repeat (3) tick();
        settle();
        chk("reset_outs", 64'(any_out()), 64'd0);
        tick();
        reset_n = 1'b1;

        // ---- no calibration: nothing accepted ----
        wv = '{rnw: 1'b0, addr: 22'h12345, wdata: 36'hABCDEF012, be: 4'b1010};
        req_valid = 1'b1;
        req_rnw   = wv.rnw;
        req_addr  = wv.addr;
        req_wdata = wv.wdata;
        req_be    = wv.be;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (req_ready || usr_wr_strb || usr_rd_strb) bad++;
            tick();
        end
        chk("nordy_hold", 64'(bad), 64'd0);

        phy_rdy = 1'b1;
        issue(wv.rnw, wv.addr, wv.wdata, wv.be, "wr_accept");
        settle();
        chk("wr_strb", 64'(usr_wr_strb), 64'd1);
        chk("wr_no_rd", 64'(usr_rd_strb), 64'd0);
        chk("wr_addr", 64'(usr_addr), 64'h12345);
        chk("wr_data", 64'(usr_wr_data), 64'hABCDEF012);
        chk("wr_be", 64'(usr_wr_be), 64'hA);
        tick();
        settle();
        chk("wr_strb_1cyc", 64'(usr_wr_strb), 64'd0);
        chk("wr_data_held", 64'(usr_wr_data), 64'hABCDEF012);

        // ---- 8 back-to-back reads, consumer stalled ----
        tick();
        bad = 0;
        req_valid = 1'b1;
        req_rnw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = AW'(i);
            settle();
            if (!req_ready) bad++;
            tick();
        end
        chk("rd_b2b_ready", 64'(bad), 64'd0);
        req_addr = AW'(8);
        settle();
        chk("rd_stall", 64'(req_ready), 64'd0);
        req_rnw = 1'b0;
        req_addr = 22'h3FF;
        req_wdata = 36'h111111111;
        req_be = 4'hF;
        settle();
        chk("wr_while_stall", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        settle();
        chk("wr_strb_stall", 64'(usr_wr_strb), 64'd1);
        repeat (16) tick();
        settle();
        chk("all_returned", 64'(inflight), 64'd0);
        chk("fifo_head_v", 64'(rsp_valid), 64'd1);
        chk("fifo_head_d", 64'(rsp_data), 64'd0);
        req_valid = 1'b1;
        req_rnw = 1'b1;
        settle();
        chk("rd_stall_fifo", 64'(req_ready), 64'd0);
        req_valid = 1'b0;

        rsp_ready = 1'b1;
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            settle();
            if (!rsp_valid || rsp_data !== DW'(j)) bad++;
            tick();
        end
        rsp_ready = 1'b0;
        chk("drain_order", 64'(bad), 64'd0);
        settle();
        chk("drain_empty", 64'(rsp_valid), 64'd0);
        req_rnw = 1'b1;
        settle();
        chk("credits_free", 64'(req_ready), 64'd1);

        // ---- return on the same cycle as a new issue ----
        tick();
        mdl_mute = 1'b1;
        issue(1'b1, 22'h20, '0, '0, "sim_acc_a");
        tick();
        issue(1'b1, 22'h21, '0, '0, "sim_acc_b");
        inj_dvld = 1'b1;
        inj_data = 36'h55;
        settle();
        chk("sim_strb", 64'(usr_rd_strb), 64'd1);
        chk("sim_pre", 64'(inflight), 64'd1);
        tick();
        inj_dvld = 1'b0;
        settle();
        chk("sim_hold", 64'(inflight), 64'd1);
        chk("sim_rsp", 64'(rsp_data), 64'h55);
        tick();
        inj_dvld = 1'b1;
        inj_data = 36'h66;
        tick();
        inj_dvld = 1'b0;
        settle();
        chk("sim_balanced", 64'(inflight), 64'd0);
        chk("sim_no_spur", 64'(rd_spurious), 64'd0);
        rsp_ready = 1'b1;
        settle();
        chk("sim_d0", 64'(rsp_data), 64'h55);
        tick();
        settle();
        chk("sim_d1", 64'(rsp_data), 64'h66);
        tick();
        settle();
        chk("sim_empty", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;

        // ---- timeout: two reads never returned ----
        tick();
        req_valid = 1'b1;
        req_rnw = 1'b1;
        req_addr = 22'h40;
        settle();
        tick();
        req_addr = 22'h41;
        settle();
        tick();
        req_valid = 1'b0;
        settle();
        chk("to_start", 64'(inflight), 64'd1);
        n = 0;
        while (!rd_timeout && n < 40) begin
            tick();
            settle();
            n++;
        end
        chk("to_latency", 64'(n), 64'd16);
        chk("to_flush", 64'(inflight), 64'd0);
        req_valid = 1'b1;
        settle();
        chk("to_recover", 64'(req_ready), 64'd1);
        req_valid = 1'b0;
        inj_dvld = 1'b1;
        inj_data = 36'h77;
        tick();
        inj_dvld = 1'b0;
        settle();
        chk("late_spur", 64'(rd_spurious), 64'd1);
        chk("late_drop", 64'(rsp_valid), 64'd0);
        inj_dvld = 1'b1;
        err_clr = 1'b1;
        tick();
        inj_dvld = 1'b0;
        err_clr = 1'b0;
        settle();
        chk("set_wins", 64'(rd_spurious), 64'd1);
        chk("clr_timeout", 64'(rd_timeout), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        settle();
        chk("clr_spur", 64'(rd_spurious), 64'd0);

        // ---- standalone FIFO: push and pop on full ----
        for (int i = 0; i < 8; i++) begin
            f_push = 1'b1;
            f_din = DW'(100 + i);
            tick();
        end
        f_push = 1'b0;
        settle();
        chk("f_count8", 64'(f_count), 64'd8);
        chk("f_full", 64'(f_full), 64'd1);
        f_push = 1'b1;
        f_din = DW'(200);
        f_pop = 1'b1;
        settle();
        chk("f_head", 64'(f_dout), 64'd100);
        tick();
        f_push = 1'b0;
        f_pop = 1'b0;
        settle();
        chk("f_count_pp", 64'(f_count), 64'd8);
        bad = 0;
        f_pop = 1'b1;
        for (int j = 0; j < 8; j++) begin
            settle();
            if (f_dout !== ((j < 7) ? DW'(101 + j) : DW'(200))) bad++;
            tick();
        end
        f_pop = 1'b0;
        settle();
        chk("f_drain", 64'(bad), 64'd0);
        chk("f_empty", 64'(f_empty), 64'd1);

        // ---- reset with reads in flight ----
        tick();
        mdl_mute = 1'b0;
        issue(1'b1, 22'h30, '0, '0, "rst_acc0");
        issue(1'b1, 22'h31, '0, '0, "rst_acc1");
        issue(1'b1, 22'h32, '0, '0, "rst_acc2");
        tick();
        settle();
        chk("rst_inflight3", 64'(inflight), 64'd3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_async_outs", 64'(any_out()), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        settle();
        chk("rst_no_rsp", 64'(seen), 64'd0);
        chk("rst_stray_spur", 64'(rd_spurious), 64'd1);
        chk("rst_inflight0", 64'(inflight), 64'd0);

        // ---- calibration failure drops ready in the same cycle ----
        req_valid = 1'b1;
        req_rnw = 1'b0;
        settle();
        chk("cal_ready", 64'(req_ready), 64'd1);
        cal_fail = 1'b1;
        settle();
        chk("calfail_drop", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
